// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared RV32I decode definitions: base-set opcode values, immediate format
// codes, the decode-stage buffer states and the buffered entry layout.
// No ports (package).
package rv32i_pkg;

    // Major opcodes (instr[6:0]) of the RV32I base set
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // Immediate format codes
    localparam logic [2:0] IMM_I     = 3'd0;
    localparam logic [2:0] IMM_B     = 3'd1;
    localparam logic [2:0] IMM_S     = 3'd2;
    localparam logic [2:0] IMM_U     = 3'd3;
    localparam logic [2:0] IMM_J     = 3'd4;
    localparam logic [2:0] IMM_SHAMT = 3'd5;
    localparam logic [2:0] IMM_NONE  = 3'd7;

    // OP-IMM funct3 values that carry a shift amount instead of an immediate
    localparam logic [2:0] F3_SLLI      = 3'b001;
    localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

    // Two-entry buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } buf_state_t;

    // One decoded instruction as held in the head or skid slot
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm_type;
        logic [31:0] imm;
        logic        illegal;
    } dec_entry_t;

    localparam dec_entry_t ENTRY_RESET = '{
        instr:    32'd0,
        pc:       32'd0,
        imm_type: IMM_NONE,
        imm:      32'd0,
        illegal:  1'b0
    };

endpackage

// File: rtl/imm_extractor.sv
// imm_extractor
// Purely combinational RV32I immediate generator. Rebuilds the 32-bit
// immediate of the selected format from the instruction bits; unknown or
// "none" formats give zero.
// Ports:
//   instr_i     [31:7] instruction word without the opcode field
//   imm_type_i  [2:0]  format code (IMM_I .. IMM_SHAMT, IMM_NONE)
//   imm_o       [31:0] sign- or zero-extended immediate
module imm_extractor
    import rv32i_pkg::*;
(
    input  logic [31:7] instr_i,
    input  logic [2:0]  imm_type_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (imm_type_i)
            IMM_I:     imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:     imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            // B and J scramble the offset bits; bit 0 is always zero
            IMM_B:     imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:     imm_o = {instr_i[31:12], 12'd0};
            IMM_J:     imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            IMM_SHAMT: imm_o = {27'd0, instr_i[24:20]};
            default:   imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// Decode-stage front end: classifies each fetched RV32I instruction into an
// immediate format, extracts the immediate, and hands instruction, PC, format,
// immediate and illegal flag to EX through a two-entry (head + skid) buffer.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; the sender holds valid and its payload until that edge, and
// ready never depends combinationally on valid in the same cycle.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      IF -> decode handshake (in_ready is a register)
//   in_instr, in_pc        fetched word and its PC
//   flush                  drop every held and incoming instruction
//   out_valid/out_ready    decode -> EX handshake
//   out_instr, out_pc      head entry instruction and PC
//   out_imm_type, out_imm  head entry format code and immediate
//   out_illegal            head entry opcode outside RV32I base set
//   dbg_state_o            buffer state (EMPTY/FULL/SKID) for observation
module imm_decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_imm_type,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic [1:0]      dbg_state_o
);

    buf_state_t  state_q, state_d;
    dec_entry_t  head_q, skid_q;
    dec_entry_t  new_entry;
    logic        in_ready_q;
    logic [2:0]  imm_type_sel;
    logic        illegal_sel;
    logic [31:0] imm_sel;
    logic        accept;
    logic        drain;

    // Format selection from the opcode (and funct3 for OP-IMM shifts)
    always_comb begin
        imm_type_sel = IMM_NONE;
        illegal_sel  = 1'b0;
        case (in_instr[6:0])
            OPC_LUI, OPC_AUIPC:            imm_type_sel = IMM_U;
            OPC_JAL:                       imm_type_sel = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_SYSTEM: imm_type_sel = IMM_I;
            OPC_BRANCH:                    imm_type_sel = IMM_B;
            OPC_STORE:                     imm_type_sel = IMM_S;
            OPC_OPIMM: begin
                if (in_instr[14:12] == F3_SLLI || in_instr[14:12] == F3_SRLI_SRAI) begin
                    imm_type_sel = IMM_SHAMT;
                end else begin
                    imm_type_sel = IMM_I;
                end
            end
            OPC_OP, OPC_MISCMEM:           imm_type_sel = IMM_NONE;
            default: begin
                imm_type_sel = IMM_NONE;
                illegal_sel  = 1'b1;
            end
        endcase
    end

    imm_extractor u_imm_extractor (
        .instr_i    (in_instr[31:7]),
        .imm_type_i (imm_type_sel),
        .imm_o      (imm_sel)
    );

    always_comb begin
        new_entry.instr    = in_instr;
        new_entry.pc       = in_pc;
        new_entry.imm_type = imm_type_sel;
        new_entry.imm      = imm_sel;
        new_entry.illegal  = illegal_sel;
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept && !drain) begin
                    state_d = ST_SKID;
                end else if (drain && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID:  if (drain) state_d = ST_FULL;
            default:  state_d = ST_EMPTY;
        endcase
        // Redirect wins over any accept or drain in the same cycle
        if (flush) state_d = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            head_q     <= ENTRY_RESET;
            skid_q     <= ENTRY_RESET;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            // Ready is derived from the next state, so out_ready never
            // reaches in_ready through combinational logic
            in_ready_q <= (state_d != ST_SKID);
            if (!flush) begin
                case (state_q)
                    ST_EMPTY: if (accept) head_q <= new_entry;
                    ST_FULL: begin
                        if (accept && drain) begin
                            head_q <= new_entry;
                        end else if (accept) begin
                            skid_q <= new_entry;
                        end
                    end
                    ST_SKID:  if (drain) head_q <= skid_q;
                    default: ;
                endcase
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_instr    = head_q.instr;
    assign out_pc       = head_q.pc;
    assign out_imm_type = head_q.imm_type;
    assign out_imm      = head_q.imm;
    assign out_illegal  = head_q.illegal;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
// Self-checking bench for imm_decode_stage: directed vectors for each format,
// back-pressure, flush and asynchronous reset, then randomized traffic. Expected
// entries come from a reference decoder written from the RV32I format rules.
module tb_imm_decode_stage;

    localparam int CLK_HALF = 5;
    localparam int EXP_W    = 100;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm_type;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  out_imm_type;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic [1:0]  dbg_state;

    always #CLK_HALF clk = ~clk;

    imm_decode_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_imm_type (out_imm_type),
        .out_imm      (out_imm),
        .out_illegal  (out_illegal),
        .dbg_state_o  (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic exp_t ref_model(input logic [31:0] instr, input logic [31:0] pc);
        exp_t r;
        logic signed [31:0] s;
        logic [31:0] u;
        logic [31:0] t;
        s = instr;
        u = instr;
        r.instr = instr;
        r.pc = pc;
        r.imm_type = 3'd7;
        r.imm = 32'd0;
        r.illegal = 1'b0;
        case (instr[6:0])
            7'h37, 7'h17: begin
                r.imm_type = 3'd3;
                r.imm = u & 32'hFFFF_F000;
            end
            7'h6F: begin
                r.imm_type = 3'd4;
                t = (((u >> 21) & 32'd1023) << 1) + (((u >> 20) & 32'd1) << 11)
                    + (((u >> 12) & 32'd255) << 12);
                if (instr[31]) t = t - 32'd1048576;
                r.imm = t;
            end
            7'h67, 7'h03, 7'h73: begin
                r.imm_type = 3'd0;
                r.imm = s >>> 20;
            end
            7'h63: begin
                r.imm_type = 3'd1;
                t = (((u >> 8) & 32'd15) << 1) + (((u >> 25) & 32'd63) << 5)
                    + (((u >> 7) & 32'd1) << 11);
                if (instr[31]) t = t - 32'd4096;
                r.imm = t;
            end
            7'h23: begin
                r.imm_type = 3'd2;
                t = s >>> 25;
                r.imm = (t << 5) | ((u >> 7) & 32'd31);
            end
            7'h13: begin
                if (((u >> 12) & 32'd7) == 32'd1 || ((u >> 12) & 32'd7) == 32'd5) begin
                    r.imm_type = 3'd5;
                    r.imm = (u >> 20) & 32'd31;
                end else begin
                    r.imm_type = 3'd0;
                    r.imm = s >>> 20;
                end
            end
            7'h33, 7'h0F: r.imm_type = 3'd7;
            default: begin
                r.imm_type = 3'd7;
                r.illegal = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_instr"}, out_instr, 32'd0);
        check({tag, "_out_pc"}, out_pc, 32'd0);
        check({tag, "_out_imm"}, out_imm, 32'd0);
        check({tag, "_out_imm_type"}, {29'd0, out_imm_type}, 32'd7);
        check({tag, "_out_illegal"}, {31'd0, out_illegal}, 32'd0);
        check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // ---------------- input tracker: pushes expected entries ----------------
    logic        s_rst, s_acc, s_flush;
    logic [31:0] s_instr, s_pc;
    initial begin
        forever begin
            @(negedge clk);
            s_rst   = rst_n;
            s_acc   = in_valid && in_ready;
            s_flush = flush;
            s_instr = in_instr;
            s_pc    = in_pc;
            @(posedge clk);
            if (s_rst && rst_n) begin
                if (s_flush) begin
                    exp_q.delete();
                end else if (s_acc) begin
                    exp_q.push_back(ref_model(s_instr, s_pc));
                end
            end
        end
    end

    // ---------------- output monitor: compares and pops ----------------
    exp_t act_e, exp_e, prev_e;
    logic prev_hold = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            act_e = '{out_instr, out_pc, out_imm_type, out_imm, out_illegal};
            if (prev_hold) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                checks++;
                if (act_e !== prev_e) begin
                    errors++;
                    $display("FAIL hold_stable: got %h expected %h", act_e, prev_e);
                end
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got instr %h pc %h with nothing expected",
                             out_instr, out_pc);
                end else begin
                    exp_e = exp_q[0];
                    if (act_e !== exp_e) begin
                        errors++;
                        $display("FAIL entry: got instr %h pc %h type %0d imm %h ill %b expected instr %h pc %h type %0d imm %h ill %b",
                                 act_e.instr, act_e.pc, act_e.imm_type, act_e.imm, act_e.illegal,
                                 exp_e.instr, exp_e.pc, exp_e.imm_type, exp_e.imm, exp_e.illegal);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_e = act_e;
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] opc_tab[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h63,
                                7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

    initial begin
        logic [31:0] pc;
        logic [31:0] r;
        int waited;
        pc = 32'h0000_1000;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("in_reset");
        rst_n = 1'b1;
        #1;
        check_reset_values("after_reset");

        // single accept, one-cycle latency
        step(1'b1, 32'hFFF0_0093, pc, 1'b0, 1'b0); pc += 4;
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // back-to-back sw, beq, lui at full throughput
        step(1'b1, 32'h0011_2623, pc, 1'b1, 1'b0); pc += 4;
        check("b2b_ready_0", {31'd0, in_ready}, 32'd1);
        step(1'b1, 32'hFE00_0EE3, pc, 1'b1, 1'b0); pc += 4;
        check("b2b_ready_1", {31'd0, in_ready}, 32'd1);
        check("b2b_valid_1", {31'd0, out_valid}, 32'd1);
        step(1'b1, 32'h1234_50B7, pc, 1'b1, 1'b0); pc += 4;
        check("b2b_ready_2", {31'd0, in_ready}, 32'd1);
        check("b2b_state_2", {30'd0, dbg_state}, 32'd1);
        step(1'b1, 32'h0030_9093, pc, 1'b1, 1'b0); pc += 4;
        step(1'b1, 32'hFF9F_F06F, pc, 1'b1, 1'b0); pc += 4;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("b2b_idle", {31'd0, out_valid}, 32'd1 - 32'd1);

        // back-pressure into SKID, then release
        step(1'b1, 32'hFFF0_0093, pc, 1'b0, 1'b0); pc += 4;
        step(1'b1, 32'h0011_2623, pc, 1'b0, 1'b0); pc += 4;
        check("skid_in_ready", {31'd0, in_ready}, 32'd0);
        check("skid_state", {30'd0, dbg_state}, 32'd2);
        step(1'b1, 32'h1234_50B7, pc, 1'b0, 1'b0);
        check("skid_hold_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 32'h1234_50B7, pc, 1'b1, 1'b0);
        check("skid_release_ready", {31'd0, in_ready}, 32'd1);
        step(1'b1, 32'h1234_50B7, pc, 1'b1, 1'b0); pc += 4;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("skid_drained", {31'd0, out_valid}, 32'd0);

        // flush while in SKID with a word on the input
        step(1'b1, 32'h0000_0513, pc, 1'b0, 1'b0); pc += 4;
        step(1'b1, 32'h0040_0593, pc, 1'b0, 1'b0); pc += 4;
        check("flush_pre_state", {30'd0, dbg_state}, 32'd2);
        step(1'b1, 32'h0080_0613, pc, 1'b0, 1'b1); pc += 4;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("flush_stays_empty", {31'd0, out_valid}, 32'd0);

        // unsupported opcode
        step(1'b1, 32'h0000_007F, pc, 1'b1, 1'b0); pc += 4;
        check("illegal_flag", {31'd0, out_illegal}, 32'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // asynchronous reset mid-stream
        step(1'b1, 32'h0011_2623, pc, 1'b0, 1'b0); pc += 4;
        step(1'b1, 32'hFE00_0EE3, pc, 1'b0, 1'b0); pc += 4;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom();
            if ($urandom_range(0, 7) != 0) r[6:0] = opc_tab[$urandom_range(0, 11)];
            step($urandom_range(0, 9) < 7, r, pc, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0);
            pc += 4;
        end

        // drain whatever is left, bounded
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
